// File: rtl/feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | feeder_pkg : shared types and sizing helpers for the skewed data feeder     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package feeder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feeder_state_t;

  localparam int C_ELEM_W = 8;
  typedef logic [C_ELEM_W-1:0] elem_t;

  // Steps per burst: DEPTH elements plus ROWS-1 steps of diagonal skew.
  function automatic int steps_f(input int depth, input int rows);
    return depth + rows - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/feeder_row_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | feeder_row_shifter : one row's element shift register, emitting MS element |
// | first once the global step reaches this row's skew offset. Rev 1.0         |
// +----------------------------------------------------------------------------+
module feeder_row_shifter
  import feeder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7,
  parameter int ROW    = 0,
  parameter int STEP_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    step,
  input  logic                    clear,
  input  logic [STEP_W-1:0]       step_idx,
  input  logic [DEPTH*DATA_W-1:0] row_data,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out
);

  localparam logic [STEP_W-1:0] C_FIRST = STEP_W'(ROW);
  localparam logic [STEP_W-1:0] C_DEPTH = STEP_W'(DEPTH);

  logic [DEPTH*DATA_W-1:0] r_shift;
  logic [STEP_W-1:0]       w_off;
  logic                    w_active;

  // Steps before this row's start wrap to a value >= DEPTH, so one compare suffices.
  assign w_off    = step_idx - C_FIRST;
  assign w_active = (w_off < C_DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      if (load) begin
        r_shift <= row_data;
      end else if (step && w_active) begin
        r_shift <= r_shift << DATA_W;
      end

      if (clear) begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end else if (step) begin
        if (w_active) begin
          data_out  <= r_shift[DEPTH*DATA_W-1 -: DATA_W];
          valid_out <= 1'b1;
        end else begin
          data_out  <= '0;
          valid_out <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/skewed_data_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skewed_data_feeder : loads ROWS x DEPTH burst, serialises rows on a        |
// | diagonal wavefront into the systolic array edge. Rev 1.0                   |
// +----------------------------------------------------------------------------+
module skewed_data_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7,
  parameter int ROWS   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [ROWS*DEPTH*DATA_W-1:0] load_data,
  input  logic                         enable,
  output logic [ROWS*DATA_W-1:0]       data_out,
  output logic [ROWS-1:0]              valid_out,
  output logic                         busy,
  output logic                         done
);

  localparam int                  C_STEPS     = steps_f(DEPTH, ROWS);
  localparam int                  C_STEP_W    = $clog2(C_STEPS + 1);
  localparam logic [C_STEP_W-1:0] C_LAST_STEP = C_STEP_W'(C_STEPS - 1);
  localparam logic [C_STEP_W-1:0] C_ONE       = C_STEP_W'(1);

  feeder_state_t         r_state;
  logic [C_STEP_W-1:0]   r_step;
  logic                  r_done;
  logic                  w_idle;
  logic                  w_accept;
  logic                  w_step;

  assign w_idle     = (r_state == IDLE);
  assign w_accept   = w_idle && load_valid;
  assign w_step     = (r_state == RUN) && enable;
  assign load_ready = w_idle;
  assign busy       = !w_idle;
  assign done       = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_state <= RUN;
            r_step  <= '0;
          end
        end
        RUN: begin
          if (enable) begin
            if (r_step == C_LAST_STEP) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_step <= r_step + C_ONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    feeder_row_shifter #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ROW    (r),
      .STEP_W (C_STEP_W)
    ) u_row (
      .clk       (clk),
      .reset     (reset),
      .load      (w_accept),
      .step      (w_step),
      .clear     (w_idle),
      .step_idx  (r_step),
      .row_data  (load_data[r*DEPTH*DATA_W +: DEPTH*DATA_W]),
      .data_out  (data_out[r*DATA_W +: DATA_W]),
      .valid_out (valid_out[r])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_skewed_data_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_skewed_data_feeder : randomized and directed bench with an element-     |
// | indexed reference model; also exercises a ROWS=1 build. Rev 1.0            |
// +----------------------------------------------------------------------------+
module tb_skewed_data_feeder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 7;
  localparam int ROWS   = 4;
  localparam int STEPS  = DEPTH + ROWS - 1;
  localparam int LD_W   = ROWS * DEPTH * DATA_W;
  localparam int RW     = DEPTH * DATA_W;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   load_valid;
  logic                   load_ready;
  logic [LD_W-1:0]        load_data;
  logic                   enable;
  logic [ROWS*DATA_W-1:0] data_out;
  logic [ROWS-1:0]        valid_out;
  logic                   busy;
  logic                   done;

  logic                   lv1;
  logic                   lr1;
  logic [RW-1:0]          ld1;
  logic                   en1;
  logic [DATA_W-1:0]      do1;
  logic [0:0]             vo1;
  logic                   busy1;
  logic                   done1;

  always #5 clk = ~clk;

  skewed_data_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(ROWS)) u_dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .enable(enable), .data_out(data_out),
    .valid_out(valid_out), .busy(busy), .done(done)
  );

  skewed_data_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(1)) u_dut1 (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(lr1),
    .load_data(ld1), .enable(en1), .data_out(do1),
    .valid_out(vo1), .busy(busy1), .done(done1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: elements stored by index, output chosen by k = s - r.
  logic [DATA_W-1:0] m_elem [ROWS][DEPTH];
  logic [DATA_W-1:0] m_data [ROWS];
  logic              m_valid[ROWS];
  bit                m_busy;
  bit                m_done;
  int                m_s;

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) begin
      m_data[r]  = '0;
      m_valid[r] = 1'b0;
    end
    m_busy = 0;
    m_done = 0;
    m_s    = 0;
  endtask

  task automatic model_update();
    if (!m_busy) begin
      m_done = 0;
      for (int r = 0; r < ROWS; r++) begin
        m_data[r]  = '0;
        m_valid[r] = 1'b0;
      end
      if (load_valid) begin
        for (int r = 0; r < ROWS; r++)
          for (int k = 0; k < DEPTH; k++)
            m_elem[r][k] = load_data[r*RW + (DEPTH-1-k)*DATA_W +: DATA_W];
        m_s    = 0;
        m_busy = 1;
      end
    end else begin
      m_done = 0;
      if (enable) begin
        for (int r = 0; r < ROWS; r++) begin
          int k;
          k = m_s - r;
          if (k >= 0 && k < DEPTH) begin
            m_data[r]  = m_elem[r][k];
            m_valid[r] = 1'b1;
          end else begin
            m_data[r]  = '0;
            m_valid[r] = 1'b0;
          end
        end
        if (m_s == STEPS - 1) begin
          m_done = 1;
          m_busy = 0;
        end else begin
          m_s++;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [ROWS*DATA_W-1:0] ed;
    logic [ROWS-1:0]        ev;
    for (int r = 0; r < ROWS; r++) begin
      ed[r*DATA_W +: DATA_W] = m_data[r];
      ev[r]                  = m_valid[r];
    end
    check_eq({tag, " data_out"},   data_out,   ed);
    check_eq({tag, " valid_out"},  valid_out,  ev);
    check_eq({tag, " busy"},       busy,       m_busy);
    check_eq({tag, " done"},       done,       m_done);
    check_eq({tag, " load_ready"}, load_ready, !m_busy);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    #1;
    compare_all(tag);
  endtask

  task automatic rand_data(output logic [LD_W-1:0] d);
    for (int i = 0; i < ROWS*DEPTH; i++) d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  task automatic start_burst(input string tag, input logic [LD_W-1:0] d);
    load_data  = d;
    load_valid = 1'b1;
    enable     = 1'b0;
    cycle(tag);
    load_valid = 1'b0;
  endtask

  // mode 0: enable high, 1: alternating, 2: random enable and load noise.
  task automatic run_until_done(input string tag, input int mode, input int max_cycles,
                                output int n_en);
    bit seen;
    logic [LD_W-1:0] d;
    seen = 0;
    n_en = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      case (mode)
        0:       enable = 1'b1;
        1:       enable = (i % 2 == 0);
        default: begin
          enable     = ($urandom_range(0, 3) != 0);
          load_valid = $urandom_range(0, 1);
          rand_data(d);
          load_data  = d;
        end
      endcase
      if (m_busy && enable) n_en++;
      cycle(tag);
      if (m_done) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", tag, max_cycles);
    end
  endtask

  logic [LD_W-1:0] t1_data;
  logic [LD_W-1:0] d;
  int              n_en;

  initial begin
    t1_data = {56'h81828384858687, 56'h01020304050607,
               56'hA1B2C3D4E5F607, 56'h11223344556677};
    reset = 1'b1; load_valid = 1'b0; load_data = '0; enable = 1'b0;
    lv1 = 1'b0; ld1 = '0; en1 = 1'b0;
    model_reset();
    #2;
    compare_all("reset");
    cycle("reset_hold");
    reset = 1'b0;
    cycle("idle");

    // Test 1: fixed burst, enable held high.
    start_burst("t1_load", t1_data);
    enable = 1'b1;
    for (int i = 0; i < STEPS; i++) begin
      cycle("t1");
      if (i == 0) begin
        check_eq("t1 s0 row0", data_out[7:0], 8'h11);
        check_eq("t1 s0 valid", valid_out, 4'b0001);
      end
      if (i == 3) begin
        check_eq("t1 s3 row0", data_out[7:0], 8'h44);
        check_eq("t1 s3 row2", data_out[23:16], 8'h02);
        check_eq("t1 s3 row3", data_out[31:24], 8'h81);
        check_eq("t1 s3 valid", valid_out, 4'b1111);
      end
      if (i == 8) check_eq("t1 s8 done", done, 1'b0);
      if (i == 9) begin
        check_eq("t1 s9 row3", data_out[31:24], 8'h87);
        check_eq("t1 s9 valid", valid_out, 4'b1000);
        check_eq("t1 s9 done", done, 1'b1);
      end
    end
    enable = 1'b0;
    cycle("t1_after");

    // Test 2: same burst, enable alternating.
    start_burst("t2_load", t1_data);
    run_until_done("t2", 1, 40, n_en);
    check_eq("t2 enabled steps", n_en, STEPS);
    cycle("t2_after");

    // Test 3: load attempt while busy is ignored.
    start_burst("t3_load", t1_data);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) cycle("t3");
    rand_data(d);
    load_data  = d;
    load_valid = 1'b1;
    cycle("t3_pulse");
    check_eq("t3 ready low", load_ready, 1'b0);
    load_valid = 1'b0;
    run_until_done("t3", 0, 20, n_en);
    cycle("t3_after");

    // Test 4: load_valid held; second burst accepted on the done cycle.
    load_data  = t1_data;
    load_valid = 1'b1;
    enable     = 1'b1;
    cycle("t4_load");
    run_until_done("t4a", 0, 20, n_en);
    rand_data(d);
    load_data = d;
    cycle("t4_accept");
    load_valid = 1'b0;
    cycle("t4_step0");
    check_eq("t4 step0 valid", valid_out[0], 1'b1);
    check_eq("t4 step0 data", data_out[7:0], d[RW-1 -: DATA_W]);
    run_until_done("t4b", 0, 20, n_en);
    cycle("t4_after");

    // Test 5: asynchronous reset mid-burst.
    rand_data(d);
    start_burst("t5_load", d);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) cycle("t5");
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("t5_async");
    cycle("t5_hold");
    reset = 1'b0;
    cycle("t5_release");
    rand_data(d);
    start_burst("t5_fresh", d);
    run_until_done("t5_fresh", 2, 80, n_en);

    // Randomized bursts with random pacing and load noise.
    for (int b = 0; b < 8; b++) begin
      load_valid = 1'b0;
      if (!m_busy) begin
        rand_data(d);
        start_burst("rnd_load", d);
      end
      run_until_done("rnd", 2, 80, n_en);
    end
    load_valid = 1'b0;
    enable     = 1'b1;
    for (int i = 0; i < 3*STEPS && m_busy; i++) cycle("drain");
    cycle("drain_idle");

    // Test 6: ROWS=1 build is an unskewed serialiser.
    ld1 = 56'h11223344556677;
    lv1 = 1'b1;
    @(posedge clk); #1;
    lv1 = 1'b0;
    en1 = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      check_eq("t6 data", do1, DATA_W'((i + 1) * 8'h11));
      check_eq("t6 valid", vo1, 1'b1);
      check_eq("t6 done", done1, (i == DEPTH - 1));
    end
    @(posedge clk); #1;
    check_eq("t6 clear valid", vo1, 1'b0);
    check_eq("t6 clear done", done1, 1'b0);
    check_eq("t6 ready", lr1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
